// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M-style multiply/divide unit, one bit per cycle, valid/ready on both sides.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [2:0]       md_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] op;
  logic neg;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0] rem;
  logic [WIDTH-1:0] b_mag;
  logic sa_en, sb_en, sa, sb, div_zero, ovf, early, neg_in;
  logic [WIDTH-1:0] a_abs, b_abs, early_res;
  logic [WIDTH:0] mul_sum, shifted, diff;
  logic ge;
  logic [2*WIDTH-1:0] acc_mul, acc_div, prod;
  logic [WIDTH-1:0] q_s, r_s, res;
  always_comb begin
    sa_en = (md_op == 3'b001) || (md_op == 3'b010) || (md_op == 3'b100) || (md_op == 3'b110);
    sb_en = (md_op == 3'b001) || (md_op == 3'b100) || (md_op == 3'b110);
    sa = sa_en && inA[WIDTH-1];
    sb = sb_en && inB[WIDTH-1];
    a_abs = sa ? -inA : inA;
    b_abs = sb ? -inB : inB;
    div_zero = md_op[2] && (inB == '0);
    ovf = md_op[2] && !md_op[0] && (inA == {1'b1, {(WIDTH-1){1'b0}}}) && (&inB);
    early = div_zero || ovf;
    early_res = div_zero ? (md_op[1] ? inA : '1) : (md_op[1] ? '0 : inA);
    neg_in = (md_op[2] && md_op[1]) ? sa : (sa ^ sb);
  end
  // multiplier sits in acc low half and shifts out; dividend/quotient shares the same slot
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
    acc_mul = {mul_sum, acc[WIDTH-1:1]};
    shifted = {rem[WIDTH-1:0], acc[WIDTH-1]};
    diff = shifted - {1'b0, b_mag};
    ge = !diff[WIDTH];
    acc_div = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ge};
    prod = neg ? -acc : acc;
    q_s = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_s = neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    res = !op[2] ? ((op[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]) : (op[1] ? r_s : q_s);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = in_valid ? (early ? DONE : CALC) : IDLE;
      CALC: state_nx = (cnt == '0) ? SIGN : CALC;
      SIGN: state_nx = DONE;
      DONE: state_nx = out_ready ? IDLE : DONE;
    endcase
    if (flush) state_nx = IDLE;
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op <= '0;
      neg <= 1'b0;
      cnt <= '0;
      acc <= '0;
      rem <= '0;
      b_mag <= '0;
      out <= '0;
    end else if (!flush) begin
      if (state == IDLE && in_valid) begin
        op <= md_op;
        neg <= neg_in;
        cnt <= CNT_W'(WIDTH-1);
        acc <= {{WIDTH{1'b0}}, a_abs};
        rem <= '0;
        b_mag <= b_abs;
        if (early) out <= early_res;
      end else if (state == CALC) begin
        cnt <= cnt - 1'b1;
        acc <= op[2] ? acc_div : acc_mul;
        if (op[2]) rem <= ge ? diff : shifted;
      end else if (state == SIGN) begin
        out <= res;
      end
    end
  end
endmodule
